// File: rtl/alt_mem_ddrx_id_pool.sv
// Multi-port free-ID pool: circular free list with one get port and
// several put ports, allocation tracking and a sticky illegal-put flag.
module alt_mem_ddrx_id_pool #(
  parameter int    CTL_LIST_WIDTH      = 3,
  parameter int    CTL_LIST_DEPTH      = 8,
  parameter int    CTL_PUT_PORTS       = 2,
  parameter string CTL_LIST_INIT_VALID = "VALID"
) (
  input  logic                                   ctl_clk,
  input  logic                                   ctl_reset_n,
  input  logic                                   list_get_entry_ready,
  output logic                                   list_get_entry_valid,
  output logic [CTL_LIST_WIDTH-1:0]              list_get_entry_id,
  output logic [CTL_LIST_DEPTH-1:0]              list_get_entry_id_vector,
  input  logic [CTL_PUT_PORTS-1:0]               list_put_entry_valid,
  input  logic [CTL_PUT_PORTS*CTL_LIST_WIDTH-1:0] list_put_entry_id,
  output logic [CTL_LIST_WIDTH:0]                list_free_count,
  output logic [CTL_LIST_DEPTH-1:0]              list_alloc_vector,
  input  logic                                   list_err_clear,
  output logic                                   list_err_put
);

  localparam int W  = CTL_LIST_WIDTH;
  localparam int D  = CTL_LIST_DEPTH;
  localparam int P  = CTL_PUT_PORTS;
  localparam int CW = W + 1;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam bit INIT_FULL = (CTL_LIST_INIT_VALID == "VALID");

  logic [W-1:0]  mem [D];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [D-1:0]  alloc;
  logic          err;

  logic [W-1:0]  put_id   [P];
  logic [PW-1:0] put_slot [P];
  logic [P-1:0]  put_ok;
  logic [W-1:0]  head;
  logic          get_fire;
  logic          owned;
  logic          dup;
  logic          err_hit;
  int            nacc;
  logic [D-1:0]  alloc_nxt;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;

  // Pointer math is modulo DEPTH; n never exceeds DEPTH so one fold suffices
  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] b,
    input int            n
  );
    int s;
    s = int'(b) + n;
    if (s >= D) s = s - D;
    return PW'(s);
  endfunction

  always_comb begin
    head      = mem[rd_ptr];
    get_fire  = (count != '0) && list_get_entry_ready;
    alloc_nxt = alloc;
    nacc      = 0;
    err_hit   = 1'b0;
    owned     = 1'b0;
    dup       = 1'b0;
    put_ok    = '0;
    for (int i = 0; i < D; i++) begin
      if (get_fire && head == W'(i)) alloc_nxt[i] = 1'b1;
    end
    for (int p = 0; p < P; p++) begin
      put_id[p] = list_put_entry_id[p*W +: W];
      owned = 1'b0;
      for (int i = 0; i < D; i++) begin
        if (put_id[p] == W'(i)) owned = alloc[i];
      end
      dup = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (list_put_entry_valid[q] && put_id[q] == put_id[p]) dup = 1'b1;
      end
      put_ok[p]   = list_put_entry_valid[p] && owned && !dup;
      put_slot[p] = wrap_add(wr_ptr, nacc);
      if (put_ok[p]) begin
        nacc = nacc + 1;
        for (int i = 0; i < D; i++) begin
          if (put_id[p] == W'(i)) alloc_nxt[i] = 1'b0;
        end
      end
      if (list_put_entry_valid[p] && !put_ok[p]) err_hit = 1'b1;
    end
    wr_ptr_nxt = wrap_add(wr_ptr, nacc);
    rd_ptr_nxt = get_fire ? wrap_add(rd_ptr, 1) : rd_ptr;
    count_nxt  = CW'(int'(count) - (get_fire ? 1 : 0) + nacc);
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      for (int i = 0; i < D; i++) begin
        mem[i] <= INIT_FULL ? W'(i) : '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= INIT_FULL ? CW'(D) : '0;
      alloc  <= INIT_FULL ? '0 : '1;
      err    <= 1'b0;
    end else begin
      for (int p = 0; p < P; p++) begin
        if (put_ok[p]) mem[put_slot[p]] <= put_id[p];
      end
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      alloc  <= alloc_nxt;
      err    <= (err && !list_err_clear) || err_hit;
    end
  end

  always_comb begin
    list_get_entry_id_vector = '0;
    for (int i = 0; i < D; i++) begin
      if (count != '0 && head == W'(i)) list_get_entry_id_vector[i] = 1'b1;
    end
  end

  assign list_get_entry_valid = (count != '0);
  assign list_get_entry_id    = head;
  assign list_free_count      = count;
  assign list_alloc_vector    = alloc;
  assign list_err_put         = err;

endmodule

// File: tb/tb_alt_mem_ddrx_id_pool.sv
// Directed bench for alt_mem_ddrx_id_pool across three configurations.
module tb_alt_mem_ddrx_id_pool;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // u0: W=3 D=8 VALID
  logic       a_rdy, a_vld, a_clr, a_err;
  logic [2:0] a_id;
  logic [7:0] a_vec, a_alloc;
  logic [1:0] a_pv;
  logic [5:0] a_pid;
  logic [3:0] a_cnt;

  // u1: W=4 D=8 VALID
  logic       b_rdy, b_vld, b_clr, b_err;
  logic [3:0] b_id;
  logic [7:0] b_vec, b_alloc;
  logic [1:0] b_pv;
  logic [7:0] b_pid;
  logic [4:0] b_cnt;

  // u2: W=3 D=6 INVALID
  logic       c_rdy, c_vld, c_clr, c_err;
  logic [2:0] c_id;
  logic [5:0] c_vec, c_alloc;
  logic [1:0] c_pv;
  logic [5:0] c_pid;
  logic [3:0] c_cnt;

  alt_mem_ddrx_id_pool #(
    .CTL_LIST_WIDTH(3), .CTL_LIST_DEPTH(8),
    .CTL_PUT_PORTS(2), .CTL_LIST_INIT_VALID("VALID")
  ) u0 (
    .ctl_clk(clk), .ctl_reset_n(rst_n),
    .list_get_entry_ready(a_rdy), .list_get_entry_valid(a_vld),
    .list_get_entry_id(a_id), .list_get_entry_id_vector(a_vec),
    .list_put_entry_valid(a_pv), .list_put_entry_id(a_pid),
    .list_free_count(a_cnt), .list_alloc_vector(a_alloc),
    .list_err_clear(a_clr), .list_err_put(a_err)
  );

  alt_mem_ddrx_id_pool #(
    .CTL_LIST_WIDTH(4), .CTL_LIST_DEPTH(8),
    .CTL_PUT_PORTS(2), .CTL_LIST_INIT_VALID("VALID")
  ) u1 (
    .ctl_clk(clk), .ctl_reset_n(rst_n),
    .list_get_entry_ready(b_rdy), .list_get_entry_valid(b_vld),
    .list_get_entry_id(b_id), .list_get_entry_id_vector(b_vec),
    .list_put_entry_valid(b_pv), .list_put_entry_id(b_pid),
    .list_free_count(b_cnt), .list_alloc_vector(b_alloc),
    .list_err_clear(b_clr), .list_err_put(b_err)
  );

  alt_mem_ddrx_id_pool #(
    .CTL_LIST_WIDTH(3), .CTL_LIST_DEPTH(6),
    .CTL_PUT_PORTS(2), .CTL_LIST_INIT_VALID("INVALID")
  ) u2 (
    .ctl_clk(clk), .ctl_reset_n(rst_n),
    .list_get_entry_ready(c_rdy), .list_get_entry_valid(c_vld),
    .list_get_entry_id(c_id), .list_get_entry_id_vector(c_vec),
    .list_put_entry_valid(c_pv), .list_put_entry_id(c_pid),
    .list_free_count(c_cnt), .list_alloc_vector(c_alloc),
    .list_err_clear(c_clr), .list_err_put(c_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({a_vld, a_id, a_vec} !== {1'b1, 3'd0, 8'h01}) begin
      failures++;
      $display("FAIL reset_head got v=%0b id=%0d vec=%h want v=1 id=0 vec=01",
               a_vld, a_id, a_vec);
    end
    checks++;
    if ({a_cnt, a_alloc, a_err} !== {4'd8, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got cnt=%0d alloc=%h err=%0b want 8 00 0",
               a_cnt, a_alloc, a_err);
    end
    checks++;
    if ({c_vld, c_vec, c_cnt, c_alloc, c_err} !==
        {1'b0, 6'h00, 4'd0, 6'h3F, 1'b0}) begin
      failures++;
      $display("FAIL reset_invalid got v=%0b vec=%h cnt=%0d alloc=%h err=%0b want 0 00 0 3f 0",
               c_vld, c_vec, c_cnt, c_alloc, c_err);
    end
  endtask

  task automatic test_drain();
    logic [7:0] ev;
    a_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ev = 8'h01 << i;
      checks++;
      if ({a_vld, a_id, a_vec} !== {1'b1, 3'(i), ev}) begin
        failures++;
        $display("FAIL drain_%0d got v=%0b id=%0d vec=%h want v=1 id=%0d vec=%h",
                 i, a_vld, a_id, a_vec, i, ev);
      end
      step();
    end
    a_rdy = 1'b0;
    checks++;
    if ({a_vld, a_vec, a_cnt, a_alloc} !== {1'b0, 8'h00, 4'd0, 8'hFF}) begin
      failures++;
      $display("FAIL drain_empty got v=%0b vec=%h cnt=%0d alloc=%h want 0 00 0 ff",
               a_vld, a_vec, a_cnt, a_alloc);
    end
  endtask

  task automatic test_multi_put();
    a_pv = 2'b11;
    a_pid = {3'd2, 3'd5};
    step();
    a_pv = 2'b00;
    checks++;
    if ({a_vld, a_id, a_cnt, a_alloc} !== {1'b1, 3'd5, 4'd2, 8'hDB}) begin
      failures++;
      $display("FAIL multi_put got v=%0b id=%0d cnt=%0d alloc=%h want 1 5 2 db",
               a_vld, a_id, a_cnt, a_alloc);
    end
    a_rdy = 1'b1;
    step();
    a_rdy = 1'b0;
    checks++;
    if ({a_id, a_cnt, a_alloc} !== {3'd2, 4'd1, 8'hFB}) begin
      failures++;
      $display("FAIL multi_put_get got id=%0d cnt=%0d alloc=%h want 2 1 fb",
               a_id, a_cnt, a_alloc);
    end
  endtask

  task automatic test_get_put_same_cycle();
    a_rdy = 1'b1;
    a_pv = 2'b01;
    a_pid = {3'd0, 3'd6};
    step();
    a_rdy = 1'b0;
    a_pv = 2'b00;
    checks++;
    if ({a_vld, a_id, a_cnt, a_alloc, a_err} !==
        {1'b1, 3'd6, 4'd1, 8'hBF, 1'b0}) begin
      failures++;
      $display("FAIL get_put got v=%0b id=%0d cnt=%0d alloc=%h err=%0b want 1 6 1 bf 0",
               a_vld, a_id, a_cnt, a_alloc, a_err);
    end
  endtask

  task automatic test_illegal_put();
    a_pv = 2'b01;
    a_pid = {3'd0, 3'd6};
    step();
    a_pv = 2'b00;
    checks++;
    if ({a_err, a_cnt, a_alloc, a_id} !== {1'b1, 4'd1, 8'hBF, 3'd6}) begin
      failures++;
      $display("FAIL free_put got err=%0b cnt=%0d alloc=%h id=%0d want 1 1 bf 6",
               a_err, a_cnt, a_alloc, a_id);
    end
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    checks++;
    if (a_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got %0b want 0", a_err);
    end
    a_clr = 1'b1;
    a_pv = 2'b01;
    step();
    a_pv = 2'b00;
    checks++;
    if (a_err !== 1'b1) begin
      failures++;
      $display("FAIL err_set_wins got %0b want 1", a_err);
    end
    step();
    a_clr = 1'b0;
    checks++;
    if (a_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear2 got %0b want 0", a_err);
    end
  endtask

  task automatic test_dup_put();
    a_pv = 2'b11;
    a_pid = {3'd1, 3'd1};
    step();
    a_pv = 2'b00;
    checks++;
    if ({a_cnt, a_err, a_alloc} !== {4'd2, 1'b1, 8'hBD}) begin
      failures++;
      $display("FAIL dup_put got cnt=%0d err=%0b alloc=%h want 2 1 bd",
               a_cnt, a_err, a_alloc);
    end
    a_rdy = 1'b1;
    checks++;
    if (a_id !== 3'd6) begin
      failures++;
      $display("FAIL dup_head0 got %0d want 6", a_id);
    end
    step();
    checks++;
    if (a_id !== 3'd1) begin
      failures++;
      $display("FAIL dup_head1 got %0d want 1", a_id);
    end
    step();
    a_rdy = 1'b0;
    checks++;
    if ({a_vld, a_cnt, a_alloc} !== {1'b0, 4'd0, 8'hFF}) begin
      failures++;
      $display("FAIL dup_drain got v=%0b cnt=%0d alloc=%h want 0 0 ff",
               a_vld, a_cnt, a_alloc);
    end
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
  endtask

  task automatic test_get_empty();
    a_rdy = 1'b1;
    step();
    step();
    a_rdy = 1'b0;
    checks++;
    if ({a_vld, a_cnt, a_alloc, a_err} !== {1'b0, 4'd0, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL get_empty got v=%0b cnt=%0d alloc=%h err=%0b want 0 0 ff 0",
               a_vld, a_cnt, a_alloc, a_err);
    end
  endtask

  task automatic test_out_of_range();
    b_pv = 2'b01;
    b_pid = {4'd0, 4'd9};
    step();
    b_pv = 2'b00;
    checks++;
    if ({b_err, b_cnt, b_alloc, b_id} !== {1'b1, 5'd8, 8'h00, 4'd0}) begin
      failures++;
      $display("FAIL out_of_range got err=%0b cnt=%0d alloc=%h id=%0d want 1 8 00 0",
               b_err, b_cnt, b_alloc, b_id);
    end
  endtask

  task automatic test_invalid_wrap();
    logic [5:0] ev;
    for (int k = 0; k < 3; k++) begin
      c_pv = 2'b11;
      c_pid = {3'(2*k+1), 3'(2*k)};
      step();
      checks++;
      if (c_cnt !== 4'(2*k+2)) begin
        failures++;
        $display("FAIL inv_put_%0d got cnt=%0d want %0d", k, c_cnt, 2*k+2);
      end
    end
    c_pv = 2'b00;
    checks++;
    if ({c_alloc, c_err} !== {6'h00, 1'b0}) begin
      failures++;
      $display("FAIL inv_alloc got alloc=%h err=%0b want 00 0", c_alloc, c_err);
    end
    c_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ev = 6'h01 << i;
      checks++;
      if ({c_vld, c_id, c_vec} !== {1'b1, 3'(i), ev}) begin
        failures++;
        $display("FAIL inv_get_%0d got v=%0b id=%0d vec=%h want 1 %0d %h",
                 i, c_vld, c_id, c_vec, i, ev);
      end
      step();
    end
    c_rdy = 1'b0;
    checks++;
    if ({c_cnt, c_alloc} !== {4'd0, 6'h3F}) begin
      failures++;
      $display("FAIL inv_drain got cnt=%0d alloc=%h want 0 3f", c_cnt, c_alloc);
    end
    c_pv = 2'b11;
    c_pid = {3'd5, 3'd4};
    step();
    c_pv = 2'b00;
    checks++;
    if ({c_id, c_cnt, c_alloc} !== {3'd4, 4'd2, 6'h0F}) begin
      failures++;
      $display("FAIL wrap_put got id=%0d cnt=%0d alloc=%h want 4 2 0f",
               c_id, c_cnt, c_alloc);
    end
    c_rdy = 1'b1;
    step();
    checks++;
    if (c_id !== 3'd5) begin
      failures++;
      $display("FAIL wrap_get got %0d want 5", c_id);
    end
    step();
    c_rdy = 1'b0;
    c_pv = 2'b11;
    c_pid = {3'd1, 3'd0};
    step();
    c_pv = 2'b11;
    c_pid = {3'd3, 3'd2};
    c_rdy = 1'b1;
    checks++;
    if ({c_id, c_cnt} !== {3'd0, 4'd2}) begin
      failures++;
      $display("FAIL pre_reset got id=%0d cnt=%0d want 0 2", c_id, c_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({c_vld, c_cnt, c_alloc, c_vec} !== {1'b0, 4'd0, 6'h3F, 6'h00}) begin
      failures++;
      $display("FAIL async_reset got v=%0b cnt=%0d alloc=%h vec=%h want 0 0 3f 00",
               c_vld, c_cnt, c_alloc, c_vec);
    end
    c_pv = 2'b00;
    c_rdy = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    a_rdy = 0; a_pv = 0; a_pid = 0; a_clr = 0;
    b_rdy = 0; b_pv = 0; b_pid = 0; b_clr = 0;
    c_rdy = 0; c_pv = 0; c_pid = 0; c_clr = 0;
    step();
    step();
    rst_n = 1'b1;
    test_reset();
    test_drain();
    test_multi_put();
    test_get_put_same_cycle();
    test_illegal_put();
    test_dup_put();
    test_get_empty();
    test_out_of_range();
    test_invalid_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alt_mem_ddrx_id_pool.md
Name: alt_mem_ddrx_id_pool

Overview:
- Multi-port free-ID pool for the DDRx controller's command/data-buffer ID management.
- Successor to the single-put shift-register free list:
  - accepts up to CTL_PUT_PORTS returned IDs per cycle into a circular FIFO;
  - gives out one ID per cycle;
  - tracks which IDs are allocated;
  - reports free count;
  - rejects and flags illegal returns (double free, out of range).
- Sits between the command-acceptance logic (getter) and the read/write completion paths (putters).

Parameters:
- CTL_LIST_WIDTH, 3, ID width in bits.
- CTL_LIST_DEPTH, 8, number of IDs managed (IDs 0..DEPTH-1); must be at most 2^CTL_LIST_WIDTH; need not be a power of 2.
- CTL_PUT_PORTS, 2, number of independent return ports (1..4).
- CTL_LIST_INIT_VALID, "VALID", "VALID": all IDs free at reset; "INVALID": all IDs outstanding at reset.

Ports:
- ctl_clk  in  1  clock.
- ctl_reset_n  in  1  asynchronous active-low reset.
- list_get_entry_ready  in  1  consumer takes head ID this cycle.
- list_get_entry_valid  out  1  head ID available.
- list_get_entry_id  out  CTL_LIST_WIDTH  head ID.
- list_get_entry_id_vector  out  CTL_LIST_DEPTH  one-hot of head ID; all-zero when not valid.
- list_put_entry_valid  in  CTL_PUT_PORTS  per-port return strobe.
- list_put_entry_id  in  CTL_PUT_PORTS*CTL_LIST_WIDTH  per-port returned ID; port p occupies bits [p*W +: W].
- list_free_count  out  CTL_LIST_WIDTH+1  number of free IDs held.
- list_alloc_vector  out  CTL_LIST_DEPTH  bit i = 1 when ID i is outstanding.
- list_err_clear  in  1  clears the sticky error flag.
- list_err_put  out  1  sticky illegal-put flag.

Behaviour:
- Interface: reset is ctl_reset_n, asynchronous, active-low; clock is ctl_clk. All state is registered; outputs are decoded from registers with no input-to-output combinational path.
- Storage: DEPTH-entry circular buffer, read pointer rd_ptr, write pointer wr_ptr, and count. Pointers wrap from DEPTH-1 to 0. Arithmetic is modulo DEPTH, not modulo 2^W.
- Reset, "VALID":
  - entry i = i;
  - rd_ptr = 0, wr_ptr = 0 (buffer full), count = DEPTH;
  - alloc_vector = 0, err = 0;
  - get_valid = 1, get_id = 0, id_vector = 1.
- Reset, "INVALID":
  - count = 0, rd_ptr = wr_ptr = 0;
  - alloc_vector = all ones, err = 0;
  - get_valid = 0, id_vector = 0.
- Reset asserted mid-operation: returns to the above state immediately (asynchronous). In-flight puts are discarded.
- get_valid = (count != 0).
- get fires when get_valid & get_ready. Effects at the next edge:
  - rd_ptr advances by 1;
  - alloc bit of the head ID set.
- get_ready while empty is ignored; no state change.
- Put legality per port p, evaluated against the pre-edge alloc_vector. Port p is accepted when all of:
  - valid[p];
  - id < DEPTH;
  - alloc_vector[id] = 1;
  - no lower-numbered port carries the same id with valid set this cycle.
- Illegal put: ignored, no state change except err set. Cases:
  - out-of-range ID;
  - ID not outstanding;
  - duplicate within the same cycle (higher port loses).
- Accepted puts:
  - written in ascending port order at wr_ptr, wr_ptr+1, …;
  - wr_ptr advances by the number accepted;
  - alloc bits cleared.
- Count update: count_next = count - get + accepted_puts. Overflow is impossible by construction, so no put-ready is provided.
- Simultaneous get and put:
  - both apply in the same cycle;
  - a put into an empty pool is visible at the head the following cycle (no bypass);
  - putting the ID being got this cycle is illegal (its alloc bit is still 0).
- Simultaneous get and put of the same ID index on the alloc bit: the get-set applies to the head ID, the put-clear to the returned ID. They are distinct when legal.
- Error flag: err sets on any illegal put. err_clear clears it. If a clear and a new error occur in the same cycle, set wins.
- Latency: returned ID is available for get 1 cycle after the put edge. free_count and alloc_vector update on the same edge.

Test Plan:
- Reset "VALID", DEPTH=8, get_ready held high 8 cycles -> IDs 0..7 in order; id_vector 0x01,0x02,…,0x80; then get_valid=0, free_count=0, alloc_vector=0xFF.
- After draining, same cycle put port0=5, port1=2 -> next cycle free_count=2, head=5; following get gives 2; alloc_vector=0xDB after the puts.
- Pool with free_count=1 (head 3): get and put ID 6 in the same cycle -> next cycle head=6, free_count=1, alloc bit3=1, bit6=0.
- Put ID 4 while ID 4 is free -> err=1, free_count unchanged; err_clear -> err=0 next cycle. Put ID 9 with DEPTH=8, W=4 -> err=1.
- Both ports put ID 1 in the same cycle (1 outstanding) -> one entry added, free_count +1, err=1.
- DEPTH=6, W=3, "INVALID": put 0..5 over 3 cycles, two per cycle; then get 6 -> order 0,1,2,3,4,5; pointers wrap 5->0 without hitting indices 6/7; assert reset mid-sequence -> count=0, alloc=0x3F immediately.
